servo_pwm_monitor: RTL and testbench

- Receive-side checker for the servo PWM lines (SERVO1/SERVO2) that drive the access barrier; one instance per line.
- Measures high-pulse width and period in clk cycles.
- Decodes barrier position (closed/open/moving) and flags framing faults: width out of range, period out of range, dead or stuck line.
- Sits beside the gate controller in the system top and feeds its status and diagnostics.

---
 rtl/servo_mon_pkg.sv | 37 +++
 rtl/pwm_in_cond.sv | 88 ++++++++
 rtl/servo_pwm_monitor.sv | 159 +++++++++++++++
 tb/tb_servo_pwm_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_mon_pkg.sv
// rtl/servo_mon_pkg.sv - shared types and default timing for the servo PWM monitor
//
// Holds the FSM state enum, the fault code enum, the measurement counter
// width and the default 25 MHz timing constants used by servo_pwm_monitor.
package servo_mon_pkg;

  localparam int CNT_W = 21;
  localparam int OUT_W = 20;

  localparam int DEF_PULSE_MIN  = 25000;
  localparam int DEF_PULSE_MAX  = 50000;
  localparam int DEF_CLOSED_MAX = 31250;
  localparam int DEF_OPEN_MIN   = 43750;
  localparam int DEF_PERIOD_MIN = 475000;
  localparam int DEF_PERIOD_MAX = 525000;
  localparam int DEF_TIMEOUT    = 1000000;
  localparam int DEF_GLITCH_CYC = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_WIDTH   = 2'd1,
    FLT_PERIOD  = 2'd2,
    FLT_TIMEOUT = 2'd3
  } fault_code_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// rtl/pwm_in_cond.sv - PWM input conditioning: synchronizer, optional glitch filter, edge strobes
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   pwm_in      raw servo line, asynchronous to clk
//   rise, fall  one-cycle registered strobes on conditioned edges
// Macro SERVO_MON_FILTER_EN adds a GLITCH_CYC-sample stability filter
// after the synchronizer.
module pwm_in_cond
  import servo_mon_pkg::*;
`ifdef SERVO_MON_FILTER_EN
#(
  parameter int GLITCH_CYC = DEF_GLITCH_CYC
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic sync1, sync2;
  logic vld1, vld2;
  logic armed;
  logic level, level_d;

  // armed stays low until a genuine low level has been sampled, so a line
  // that is already high when reset releases is not mistaken for a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      vld1  <= 1'b1;
      vld2  <= vld1;
      if (vld2 && !sync2) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef SERVO_MON_FILTER_EN
  localparam int STAB_W = $clog2(GLITCH_CYC + 1);

  logic [STAB_W-1:0] stab_cnt;
  logic              filt;

  // Accept a new level only after GLITCH_CYC consecutive differing samples;
  // both edges are delayed equally so widths and periods stay exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      filt     <= 1'b0;
    end else if (sync2 == filt) begin
      stab_cnt <= '0;
    end else if (stab_cnt == STAB_W'(GLITCH_CYC - 1)) begin
      filt     <= sync2;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + STAB_W'(1);
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= armed && level && !level_d;
      fall    <= armed && !level && level_d;
    end
  end

endmodule

// File: rtl/servo_pwm_monitor.sv
// rtl/servo_pwm_monitor.sv - servo PWM width/period monitor with position decode and fault flags
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   pwm_in           servo PWM line, asynchronous to clk
//   meas_valid       one-cycle strobe when width/period are published
//   pulse_width      last measured high width (cycles)
//   period           last measured rise-to-rise period (cycles)
//   pos_closed       barrier decoded closed
//   pos_open         barrier decoded open
//   fault            current measurement or line state illegal
//   fault_code       0 none, 1 width, 2 period, 3 timeout
// Macro SERVO_MON_FILTER_EN enables the input glitch filter (GLITCH_CYC).
module servo_pwm_monitor
  import servo_mon_pkg::*;
#(
  parameter int PULSE_MIN  = DEF_PULSE_MIN,
  parameter int PULSE_MAX  = DEF_PULSE_MAX,
  parameter int CLOSED_MAX = DEF_CLOSED_MAX,
  parameter int OPEN_MIN   = DEF_OPEN_MIN,
  parameter int PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
`ifdef SERVO_MON_FILTER_EN
  , parameter int GLITCH_CYC = DEF_GLITCH_CYC
`endif
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [OUT_W-1:0] pulse_width,
  output logic [OUT_W-1:0] period,
  output logic             pos_closed,
  output logic             pos_open,
  output logic             fault,
  output logic [1:0]       fault_code
);

  logic rise, fall;

`ifdef SERVO_MON_FILTER_EN
  pwm_in_cond #(
    .GLITCH_CYC (GLITCH_CYC)
  ) u_cond (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );
`else
  pwm_in_cond u_cond (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] w_lat;
  logic             timed_out;
  logic             publish;
  logic             tmo;
  fault_code_t      chk_code;

  assign timed_out = (cnt >= CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An edge in the same cycle as the timeout wins over the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (rise) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (fall)           state_nxt = ST_LOW;
        else if (timed_out) state_nxt = ST_IDLE;
      end
      ST_LOW: begin
        if (rise)           state_nxt = ST_HIGH;
        else if (timed_out) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Publish/timeout decisions and the frame check; width errors take
  // priority over period errors. cnt holds the period at the closing rise.
  always_comb begin
    publish  = 1'b0;
    tmo      = 1'b0;
    chk_code = FLT_NONE;
    case (state)
      ST_HIGH: tmo = !fall && timed_out;
      ST_LOW: begin
        publish = rise;
        tmo     = !rise && timed_out;
      end
      default: ;
    endcase
    if (!(w_lat >= CNT_W'(PULSE_MIN)) || (w_lat >= CNT_W'(PULSE_MAX + 1))) begin
      chk_code = FLT_WIDTH;
    end else if (!(cnt >= CNT_W'(PERIOD_MIN)) || (cnt >= CNT_W'(PERIOD_MAX + 1))) begin
      chk_code = FLT_PERIOD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      w_lat       <= '0;
      meas_valid  <= 1'b0;
      pulse_width <= '0;
      period      <= '0;
      pos_closed  <= 1'b0;
      pos_open    <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FLT_NONE;
    end else begin
      meas_valid <= publish;

      case (state)
        ST_IDLE: if (rise) cnt <= CNT_W'(1);
        ST_HIGH: begin
          cnt <= cnt_inc(cnt);
          if (fall) w_lat <= cnt;
        end
        ST_LOW:  cnt <= rise ? CNT_W'(1) : cnt_inc(cnt);
        default: cnt <= '0;
      endcase

      if (publish) begin
        pulse_width <= w_lat[OUT_W-1:0];
        period      <= cnt[OUT_W-1:0];
        fault       <= (chk_code != FLT_NONE);
        fault_code  <= chk_code;
        pos_closed  <= (chk_code == FLT_NONE) && !(w_lat >= CNT_W'(CLOSED_MAX + 1));
        pos_open    <= (chk_code == FLT_NONE) && (w_lat >= CNT_W'(OPEN_MIN));
      end else if (tmo) begin
        fault      <= 1'b1;
        fault_code <= FLT_TIMEOUT;
        pos_closed <= 1'b0;
        pos_open   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_monitor.sv
// tb/tb_servo_pwm_monitor.sv - self-checking bench for servo_pwm_monitor (timing scaled by 1/250)
module tb_servo_pwm_monitor;

  localparam int T_OUT = 4000;
`ifdef SERVO_MON_FILTER_EN
  localparam int MV_NEG = 4 + 8;
`else
  localparam int MV_NEG = 4;
`endif

  typedef struct {
    int high;
    int low;
    int w;
    int p;
    int cl;
    int op;
    int flt;
    int code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        meas_valid;
  logic [19:0] pulse_width;
  logic [19:0] period;
  logic        pos_closed;
  logic        pos_open;
  logic        fault;
  logic [1:0]  fault_code;

  servo_pwm_monitor #(
    .PULSE_MIN  (100),
    .PULSE_MAX  (200),
    .CLOSED_MAX (125),
    .OPEN_MIN   (175),
    .PERIOD_MIN (1900),
    .PERIOD_MAX (2100),
    .TIMEOUT    (T_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .meas_valid  (meas_valid),
    .pulse_width (pulse_width),
    .period      (period),
    .pos_closed  (pos_closed),
    .pos_open    (pos_open),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pub = 0;
  int   n_push = 0;
  vec_t sb_q[$];
  vec_t tbl[18];
  vec_t good;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v);
    sb_q.push_back(v);
    n_push++;
  endtask

  task automatic frame(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_pulse_width"}, pulse_width, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_pos_closed"}, pos_closed, 0);
    chk({tag, "_pos_open"}, pos_open, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_fault_code"}, fault_code, 0);
  endtask

  // Scoreboard: every publish is matched against the oldest expected frame.
  vec_t e;
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      n_pub++;
      if (sb_q.size() == 0) begin
        chk("unexpected_publish", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("pub_width", pulse_width, e.w);
        chk("pub_period", period, e.p);
        chk("pub_closed", pos_closed, e.cl);
        chk("pub_open", pos_open, e.op);
        chk("pub_fault", fault, e.flt);
        chk("pub_code", fault_code, e.code);
      end
    end
  end

  int base;

  initial begin
    tbl[0]  = '{100, 1900, 100, 2000, 1, 0, 0, 0};
    tbl[1]  = '{100, 1900, 100, 2000, 1, 0, 0, 0};
    tbl[2]  = '{200, 1800, 200, 2000, 0, 1, 0, 0};
    tbl[3]  = '{150, 1850, 150, 2000, 0, 0, 0, 0};
    tbl[4]  = '{240, 1760, 240, 2000, 0, 0, 1, 1};
    tbl[5]  = '{100, 2300, 100, 2400, 0, 0, 1, 2};
    tbl[6]  = '{99,  1901, 99,  2000, 0, 0, 1, 1};
    tbl[7]  = '{125, 1875, 125, 2000, 1, 0, 0, 0};
    tbl[8]  = '{126, 1874, 126, 2000, 0, 0, 0, 0};
    tbl[9]  = '{174, 1826, 174, 2000, 0, 0, 0, 0};
    tbl[10] = '{175, 1825, 175, 2000, 0, 1, 0, 0};
    tbl[11] = '{201, 1799, 201, 2000, 0, 0, 1, 1};
    tbl[12] = '{100, 1799, 100, 1899, 0, 0, 1, 2};
    tbl[13] = '{100, 1800, 100, 1900, 1, 0, 0, 0};
    tbl[14] = '{100, 2000, 100, 2100, 1, 0, 0, 0};
    tbl[15] = '{100, 2001, 100, 2101, 0, 0, 1, 2};
    tbl[16] = '{300, 2000, 300, 2300, 0, 0, 1, 1};
    tbl[17] = '{100, 1900, 100, 2000, 1, 0, 0, 0};
    good    = '{100, 1900, 100, 2000, 1, 0, 0, 0};

    // Reset held with the line toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    chk_zero("reset");
    pwm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with a quiet line: no timeout in IDLE.
    repeat (2 * T_OUT) @(negedge clk);
    chk("idle_pub_count", n_pub, 0);
    chk("idle_fault", fault, 0);
    chk("idle_code", fault_code, 0);

    // Table vectors as one continuous stream; frame i publishes at rise i+1.
    for (int i = 0; i < 18; i++) begin
      push(tbl[i]);
      frame(tbl[i].high, tbl[i].low);
      chk($sformatf("pub_count_v%0d", i), n_pub, i);
    end

    // Closing rise: publish latency of the last table frame.
    pwm_in = 1'b1;
    repeat (MV_NEG - 1) @(negedge clk);
    chk("latency_early", meas_valid, 0);
    @(negedge clk);
    chk("latency_strobe", meas_valid, 1);

    // That rise starts a good frame, then the line stays low until timeout.
    repeat (100 - MV_NEG) @(negedge clk);
    pwm_in = 1'b0;
    repeat (T_OUT - 1 - (100 - MV_NEG)) @(negedge clk);
    chk("timeout_early", fault, 0);
    @(negedge clk);
    chk("timeout_fault", fault, 1);
    chk("timeout_code", fault_code, 3);
    chk("timeout_closed", pos_closed, 0);
    chk("timeout_open", pos_open, 0);
    chk("timeout_hold_width", pulse_width, 100);
    chk("timeout_hold_period", period, 2000);

    // Recovery with two good frames.
    base = n_pub;
    push(good);
    frame(100, 1900);
    push(good);
    frame(100, 1900);
    pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    chk("recover_pub_count", n_pub, base + 2);
    chk("recover_fault", fault, 0);
    chk("recover_code", fault_code, 0);
    chk("recover_closed", pos_closed, 1);

    // Reset in the middle of a high pulse.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    base = n_pub;
    repeat (45) @(negedge clk);
    pwm_in = 1'b0;
    repeat (1900) @(negedge clk);
    push(good);
    frame(100, 1900);
    chk("postreset_no_pub", n_pub, base);
    push(good);
`ifdef SERVO_MON_FILTER_EN
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    pwm_in = 1'b0;
    repeat (900) @(negedge clk);
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    pwm_in = 1'b0;
    repeat (997) @(negedge clk);
`else
    frame(100, 1900);
`endif
    chk("postreset_pub", n_pub, base + 1);
    pwm_in = 1'b1;
    repeat (MV_NEG + 5) @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);

    chk("final_queue_empty", sb_q.size(), 0);
    chk("final_pub_total", n_pub, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
